arb_sched8: RTL and testbench

Eight-requester resource arbiter that shares one downstream resource among requesters and drives a one-hot grant plus a 3-bit grant index. It supports two modes. Fixed priority gives highest index wins, the same ordering as the team's 8:3 priority encoder. Round-robin uses a rotating pointer and a hold timeout. The grant is registered and is held while the owner keeps its request asserted.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_pick.sv | 33 +++
 rtl/arb_sched8.sv | 100 ++++++++++
 tb/tb_arb_sched8.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the eight-requester arbiter.
package arb_pkg;

  localparam int unsigned N              = 8;
  localparam int unsigned IDXW           = 3;
  localparam int unsigned MaxHoldDefault = 16;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // Decode a requester index into a one-hot grant vector.
  function automatic logic [N-1:0] idx2onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: descending from start_i with wrap when rr_i is set,
// otherwise plain highest-index-wins.
module arb_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] start_i,
  input  logic            rr_i,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  // Walk the candidates in priority order and keep the first one that is requesting.
  always_comb begin
    logic [IDXW-1:0] base;
    logic [IDXW-1:0] cand;
    logic            found;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    base  = rr_i ? start_i : IDXW'(N - 1);
    for (int unsigned i = 0; i < N; i++) begin
      // Index arithmetic is modulo N, so subtraction wraps 0 -> 7.
      cand = base - IDXW'(i);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/arb_sched8.sv
// Eight-requester arbiter: fixed-priority or round-robin pick, registered one-hot grant held
// while the owner keeps requesting, with a hold timeout in round-robin mode.
module arb_sched8
  import arb_pkg::*;
#(
  parameter int unsigned MaxHold = MaxHoldDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            mode_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            gnt_valid_o,
  output logic            timeout_o
);

  localparam logic [7:0] HoldLast = 8'(MaxHold - 1);

  arb_state_e      state_q;
  logic [N-1:0]    gnt_q;
  logic [IDXW-1:0] gnt_idx_q;
  logic            gnt_valid_q;
  logic            timeout_q;
  logic [IDXW-1:0] last_idx_q;
  logic [7:0]      hold_cnt_q;
  logic            mode_q;

  logic [IDXW-1:0] pick_start;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            owner_drop;
  logic            hold_expired;

  // Round-robin search begins just below the previous winner.
  assign pick_start = last_idx_q - IDXW'(1);

  arb_pick u_pick (
    .req_i   (req_i),
    .start_i (pick_start),
    .rr_i    (mode_i),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Release conditions for the current owner.
  always_comb begin
    owner_drop   = ~req_i[gnt_idx_q];
    hold_expired = mode_q && (hold_cnt_q == HoldLast) && (|(req_i & ~gnt_q));
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_idx_q  <= '0;
      hold_cnt_q  <= '0;
      mode_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (en_i && pick_any) begin
            state_q     <= StGrant;
            gnt_q       <= idx2onehot(pick_idx);
            gnt_idx_q   <= pick_idx;
            gnt_valid_q <= 1'b1;
            last_idx_q  <= pick_idx;
            hold_cnt_q  <= '0;
            mode_q      <= mode_i;
          end
        end
        StGrant: begin
          if (owner_drop || !en_i || hold_expired) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            // Owner drop and disable take precedence; only a pure hold expiry reports timeout.
            timeout_q   <= !owner_drop && en_i;
          end else if (hold_cnt_q != HoldLast) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_arb_sched8.sv
// Self-checking bench for arb_sched8: a directed vector table plus multi-cycle sequences.
module tb_arb_sched8;

  logic       clk;
  logic       rst_ni;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  arb_sched8 dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .en_i        (en),
    .mode_i      (mode),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [7:0] req;
    logic       en;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic et);
    check({name, ".gnt"}, 32'(gnt), 32'(eg));
    check({name, ".idx"}, 32'(gnt_idx), 32'(ei));
    check({name, ".valid"}, 32'(gnt_valid), 32'(ev));
    check({name, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req    = '0;
    en     = 1'b0;
    mode   = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [2:0] rr_order [9];
    rr_order = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    //            req    en    mode  gnt    idx   v     tmo
    vecs[0]  = '{8'hA0, 1'b1, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[1]  = '{8'h20, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h20, 1'b1, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[3]  = '{8'h20, 1'b1, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[4]  = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{8'h22, 1'b1, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0};
    vecs[7]  = '{8'h22, 1'b1, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0};
    vecs[8]  = '{8'h20, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{8'h22, 1'b1, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[10] = '{8'h22, 1'b1, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[11] = '{8'h02, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{8'h06, 1'b1, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[13] = '{8'h06, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{8'h06, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[15] = '{8'h06, 1'b1, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[16] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

    rst_ni = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    req    = '0;
    #12;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // Directed vector table, one row per clock edge.
    for (int i = 0; i < 17; i++) begin
      req  = vecs[i].req;
      en   = vecs[i].en;
      mode = vecs[i].mode;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].tmo);
    end

    // Round-robin rotation with all requesters active.
    do_reset();
    en   = 1'b1;
    mode = 1'b1;
    req  = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << rr_order[k];
      step();
      check_out($sformatf("rr%0d.first", k), oh, rr_order[k], 1'b1, 1'b0);
      step();
      check_out($sformatf("rr%0d.hold", k), oh, rr_order[k], 1'b1, 1'b0);
      req = 8'hFF & ~oh;
      step();
      check_out($sformatf("rr%0d.dead", k), 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'hFF;
    end

    // Hold timeout in round-robin mode.
    do_reset();
    en   = 1'b1;
    mode = 1'b1;
    req  = 8'h0A;
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("tmo.hold%0d.idx", k), 32'(gnt_idx), 32'd3);
      check($sformatf("tmo.hold%0d.timeout", k), 32'(timeout), 32'd0);
    end
    step();
    check_out("tmo.release", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    check_out("tmo.next", 8'h02, 3'd1, 1'b1, 1'b0);

    // Owner drop on the same edge as the hold expiry reports no timeout.
    do_reset();
    en   = 1'b1;
    mode = 1'b1;
    req  = 8'h0A;
    for (int k = 0; k < 16; k++) step();
    check("sim.pre.idx", 32'(gnt_idx), 32'd3);
    req = 8'h02;
    step();
    check_out("sim.release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Fixed mode never forces a release.
    do_reset();
    en   = 1'b1;
    mode = 1'b0;
    req  = 8'h0A;
    for (int k = 0; k < 40; k++) begin
      step();
      check($sformatf("fix%0d.idx", k), 32'(gnt_idx), 32'd3);
      check($sformatf("fix%0d.timeout", k), 32'(timeout), 32'd0);
    end

    // Enable drop during a grant, then re-enable.
    do_reset();
    en  = 1'b1;
    req = 8'h10;
    step();
    check_out("en.grant", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_out("en.off", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    step();
    check_out("en.blocked", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    check_out("en.regrant", 8'h10, 3'd4, 1'b1, 1'b0);

    // Unsampled short request pulse is never granted.
    req = 8'h00;
    step();
    #2 req = 8'h40;
    #2 req = 8'h00;
    step();
    check_out("pulse", 8'h00, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    en  = 1'b1;
    req = 8'h10;
    step();
    check_out("arst.grant", 8'h10, 3'd4, 1'b1, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_out("arst.cleared", 8'h00, 3'd0, 1'b0, 1'b0);
    #1 rst_ni = 1'b1;
    mode = 1'b1;
    req  = 8'h0C;
    step();
    check_out("arst.rr_first", 8'h08, 3'd3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
